// File: rtl/cmp_pkg.sv
// Shared types and the flag-to-result decode for the pipelined CLA comparator.
package cmp_pkg;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

    localparam int DEF_BLK_W = 4;

    // c = carry out of the MSB block, z = all diff bits zero, n = diff sign, v = signed overflow
    function automatic cmp_res_t cmp_decode(input logic c, input logic z, input logic n,
                                            input logic v, input logic signed_mode);
        cmp_res_t r;
        r.eq = z;
        if (signed_mode) begin
            r.lt = n ^ v;
            r.gt = !(n ^ v) && !z;
        end else begin
            r.lt = !c;
            r.gt = c && !z;
        end
        return r;
    endfunction

endpackage

// File: rtl/cla_block.sv
// One BLK_W-bit carry-lookahead adder block; every carry is a flat g/p sum of products.
module cla_block #(
    parameter int BLK_W = 4
) (
    input  logic [BLK_W-1:0] x,
    input  logic [BLK_W-1:0] y,
    input  logic             cin,
    output logic [BLK_W-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [BLK_W-1:0] g;
    logic [BLK_W-1:0] p;
    logic [BLK_W:0]   c;
    logic             prop;
    logic             term;

    assign g = x & y;
    assign p = x ^ y;

    // c[i] = cin.p[0..i-1] | OR_j g[j].p[j+1..i-1], expanded rather than rippled
    always_comb begin
        c    = '0;
        prop = 1'b0;
        term = 1'b0;
        c[0] = cin;
        for (int i = 1; i <= BLK_W; i++) begin
            prop = cin;
            for (int j = 0; j < i; j++) begin
                prop = prop & p[j];
            end
            c[i] = prop;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) begin
                    term = term & p[m];
                end
                c[i] = c[i] | term;
            end
        end
    end

    assign s        = p ^ c[BLK_W-1:0];
    assign cout     = c[BLK_W];
    assign c_msb_in = c[BLK_W-1];

endmodule

// File: rtl/cla_pipe_comparator.sv
// Pipelined magnitude comparator: one CLA block per stage, LSB block first, valid/ready both sides.
// Define CMP_SIGNED_EN to honour signed_mode (two's-complement compare with piped overflow).
module cla_pipe_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BLK_W = DEF_BLK_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [WIDTH-1:0] diff
);

    localparam int NBLK = WIDTH / BLK_W;
    localparam int L    = NBLK - 1;

    if (WIDTH % BLK_W != 0) begin : g_chk
        $error("cla_pipe_comparator: WIDTH must be a multiple of BLK_W");
    end

    logic     adv;
    logic     sm_eff;
    logic     v_fin;
    cmp_res_t res;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

`ifdef CMP_SIGNED_EN
    assign sm_eff = signed_mode;
`else
    logic unused_sm;
    assign unused_sm = signed_mode;
    assign sm_eff    = 1'b0;
`endif

    genvar gi;
    for (gi = 0; gi < NBLK; gi++) begin : stage
        localparam int REM = WIDTH - gi * BLK_W;   // operand bits not yet consumed
        localparam int DW  = (gi + 1) * BLK_W;     // diff bits resolved after this stage

        logic [REM-1:0]   a_in;
        logic [REM-1:0]   b_in;
        logic             cin;
        logic             z_in;
        logic             v_in;
        logic             sm_in;
        logic [DW-1:0]    diff_next;
        logic [BLK_W-1:0] s;
        logic             cout;
        logic             cmsb;

        logic             vld_reg;
        logic             c_reg;
        logic             z_reg;
        logic             sm_reg;
        logic [DW-1:0]    diff_reg;

        if (gi == 0) begin : g_src
            assign a_in      = a;
            assign b_in      = b;
            assign cin       = 1'b1;
            assign z_in      = 1'b1;
            assign v_in      = in_valid;
            assign sm_in     = sm_eff;
            assign diff_next = s;
        end else begin : g_src
            assign a_in      = stage[gi-1].g_fwd.a_reg;
            assign b_in      = stage[gi-1].g_fwd.b_reg;
            assign cin       = stage[gi-1].c_reg;
            assign z_in      = stage[gi-1].z_reg;
            assign v_in      = stage[gi-1].vld_reg;
            assign sm_in     = stage[gi-1].sm_reg;
            assign diff_next = {s, stage[gi-1].diff_reg};
        end

        cla_block #(.BLK_W(BLK_W)) u_cla (
            .x        (a_in[BLK_W-1:0]),
            .y        (~b_in[BLK_W-1:0]),
            .cin      (cin),
            .s        (s),
            .cout     (cout),
            .c_msb_in (cmsb)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_reg  <= 1'b0;
                c_reg    <= 1'b0;
                z_reg    <= 1'b0;
                sm_reg   <= 1'b0;
                diff_reg <= '0;
            end else if (adv) begin
                vld_reg  <= v_in;
                c_reg    <= cout;
                z_reg    <= z_in && (s == '0);
                sm_reg   <= sm_in;
                diff_reg <= diff_next;
            end
        end

        // Only the upper, still-unprocessed operand slices travel to the next stage
        if (gi < NBLK - 1) begin : g_fwd
            logic [REM-BLK_W-1:0] a_reg;
            logic [REM-BLK_W-1:0] b_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_reg <= '0;
                    b_reg <= '0;
                end else if (adv) begin
                    a_reg <= a_in[REM-1:BLK_W];
                    b_reg <= b_in[REM-1:BLK_W];
                end
            end
        end

`ifdef CMP_SIGNED_EN
        if (gi == NBLK - 1) begin : g_ovf
            logic v_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_reg <= 1'b0;
                end else if (adv) begin
                    v_reg <= cmsb ^ cout;
                end
            end
        end else begin : g_ovf
            logic unused_cmsb;
            assign unused_cmsb = cmsb;
        end
`else
        logic unused_cmsb;
        assign unused_cmsb = cmsb;
`endif
    end

`ifdef CMP_SIGNED_EN
    assign v_fin = stage[L].g_ovf.v_reg;
`else
    assign v_fin = 1'b0;
`endif

    assign res = cmp_decode(stage[L].c_reg, stage[L].z_reg, stage[L].diff_reg[WIDTH-1],
                            v_fin, stage[L].sm_reg);

    // Flags are gated by valid so bubbles and reset show all-zero flags
    assign out_valid = stage[L].vld_reg;
    assign gt        = out_valid && res.gt;
    assign eq        = out_valid && res.eq;
    assign lt        = out_valid && res.lt;
    assign diff      = stage[L].diff_reg;

endmodule
